channel_init_controller: RTL and testbench

- TX-side Aurora channel initialisation sequencer, directly upstream of data_controller.
- Drives its ordered_sets and channel_init_finished inputs.
- Walks lane init, channel bonding and verification using per-lane RX status, then holds the channel ready.
- Once ready, inserts periodic clock-compensation bursts.

---
 rtl/channel_init_controller.sv | 190 +++++++++++++++++++
 tb/tb_channel_init_controller.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_init_controller.sv
// TX-side Aurora channel initialisation sequencer. Brings the channel up
// through lane init, channel bonding and verification, holds it ready for
// data_controller, and inserts periodic clock-compensation bursts once ready.

package channel_init_pkg;
    typedef enum logic [2:0] {
        OS_NONE         = 3'd0,
        OS_IDLE         = 3'd1,
        OS_CHANNEL_BOND = 3'd2,
        OS_VERIFY       = 3'd3,
        OS_CLOCK_COMP   = 3'd4
    } ordered_sets_e;
endpackage

module channel_init_controller
    import channel_init_pkg::*;
#(
    parameter int MAX_LINKS        = 4,
    parameter int MAX_LINKS_SIZE   = 3,
    parameter int RESET_CYCLES     = 8,
    parameter int LANE_INIT_CYCLES = 64,
    parameter int BOND_TIMEOUT     = 1024,
    parameter int VERIFY_COUNT     = 64,
    parameter int VERIFY_TIMEOUT   = 4096,
    parameter int CC_PERIOD        = 5000,
    parameter int CC_LEN           = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      single_lane,
    input  logic [MAX_LINKS_SIZE-1:0] lane_select,
    input  logic [MAX_LINKS-1:0]      rx_lane_up,
    input  logic                      rx_bonded,
    input  logic                      rx_verify,
    output ordered_sets_e             ordered_sets,
    output logic                      channel_init_finished,
    output logic                      cc_active,
    output logic [2:0]                init_state
);

    localparam logic [2:0] S_RESET     = 3'd0;
    localparam logic [2:0] S_LANE_INIT = 3'd1;
    localparam logic [2:0] S_BOND      = 3'd2;
    localparam logic [2:0] S_VERIFY    = 3'd3;
    localparam logic [2:0] S_READY     = 3'd4;

    // One shared state-cycle counter, sized for the longest dwell/timeout.
    localparam int M1      = (RESET_CYCLES > LANE_INIT_CYCLES) ? RESET_CYCLES : LANE_INIT_CYCLES;
    localparam int M2      = (BOND_TIMEOUT > VERIFY_TIMEOUT) ? BOND_TIMEOUT : VERIFY_TIMEOUT;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int VW      = $clog2(VERIFY_COUNT + 1);
    localparam int CCW     = $clog2(CC_PERIOD + 1);
    localparam int BW      = $clog2(CC_LEN + 1);

    localparam logic [CW-1:0]  RESET_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0]  LANE_LAST  = CW'(LANE_INIT_CYCLES - 1);
    localparam logic [CW-1:0]  BOND_LAST  = CW'(BOND_TIMEOUT - 1);
    localparam logic [CW-1:0]  VTO_LAST   = CW'(VERIFY_TIMEOUT - 1);
    localparam logic [VW-1:0]  VERIFY_MAX = VW'(VERIFY_COUNT);
    localparam logic [VW-1:0]  VERIFY_LST = VW'(VERIFY_COUNT - 1);
    localparam logic [CCW-1:0] CC_LAST    = CCW'(CC_PERIOD - 1);
    localparam logic [BW-1:0]  BURST_INIT = BW'(CC_LEN - 1);

    logic [2:0]                state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [VW-1:0]             vcnt_q, vcnt_d;
    logic [CCW-1:0]            cc_cnt_q, cc_cnt_d;
    logic [BW-1:0]             burst_q, burst_d;
    logic                      single_lane_q;
    logic [MAX_LINKS_SIZE-1:0] lane_select_q;
    ordered_sets_e             ordered_sets_q, ordered_sets_d;
    logic                      finished_q, finished_d;
    logic                      cc_active_q, cc_active_d;

    logic [MAX_LINKS-1:0]      lane_hit;
    logic                      lanes_ok;
    logic                      cfg_changed;
    logic                      entering;
    logic                      stay_ready;

    // An out-of-range lane_select never matches any lane, so lanes_ok is 0.
    generate
        for (genvar gi = 0; gi < MAX_LINKS; gi++) begin : g_lane_sel
            assign lane_hit[gi] = rx_lane_up[gi] && (lane_select == MAX_LINKS_SIZE'(gi));
        end
    endgenerate

    assign lanes_ok    = single_lane ? (|lane_hit) : (&rx_lane_up);
    assign cfg_changed = (single_lane != single_lane_q) || (lane_select != lane_select_q);

    // Next-state selection; a lane drop or config change overrides everything.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:     if (cnt_q == RESET_LAST) state_d = S_LANE_INIT;
            S_LANE_INIT: if (lanes_ok && cnt_q == LANE_LAST)
                             state_d = single_lane ? S_VERIFY : S_BOND;
            S_BOND:      if (rx_bonded) state_d = S_VERIFY;
                         else if (cnt_q == BOND_LAST) state_d = S_LANE_INIT;
            S_VERIFY:    if (rx_verify && vcnt_q == VERIFY_LST) state_d = S_READY;
                         else if (cnt_q == VTO_LAST) state_d = S_LANE_INIT;
            S_READY:     state_d = S_READY;
            default:     state_d = S_RESET;
        endcase
        if ((state_q == S_BOND || state_q == S_VERIFY || state_q == S_READY) &&
            (!lanes_ok || cfg_changed)) begin
            state_d = S_LANE_INIT;
        end
    end

    assign entering   = (state_d != state_q);
    assign stay_ready = (state_q == S_READY) && (state_d == S_READY);

    // Counters and CC burst tracking; all cleared whenever the state changes.
    always_comb begin
        cnt_d       = cnt_q;
        vcnt_d      = vcnt_q;
        cc_cnt_d    = '0;
        burst_d     = '0;
        cc_active_d = 1'b0;
        if (entering) begin
            cnt_d  = '0;
            vcnt_d = '0;
        end else begin
            case (state_q)
                S_LANE_INIT: cnt_d = lanes_ok ? cnt_q + CW'(1) : '0;
                S_READY:     cnt_d = cnt_q;
                default:     cnt_d = cnt_q + CW'(1);
            endcase
            if (state_q == S_VERIFY && rx_verify && vcnt_q != VERIFY_MAX)
                vcnt_d = vcnt_q + VW'(1);
        end
        if (stay_ready) begin
            cc_cnt_d = (cc_cnt_q == CC_LAST) ? '0 : cc_cnt_q + CCW'(1);
            if (cc_cnt_q == CC_LAST) begin
                cc_active_d = 1'b1;
                burst_d     = BURST_INIT;
            end else if (cc_active_q && burst_q != '0) begin
                cc_active_d = 1'b1;
                burst_d     = burst_q - BW'(1);
            end
        end
    end

    // Output values for the upcoming cycle, derived from the next state.
    always_comb begin
        ordered_sets_d = OS_IDLE;
        case (state_d)
            S_BOND:   ordered_sets_d = (cnt_d[1:0] == 2'd0) ? OS_CHANNEL_BOND : OS_IDLE;
            S_VERIFY: ordered_sets_d = OS_VERIFY;
            S_READY:  ordered_sets_d = cc_active_d ? OS_CLOCK_COMP : OS_NONE;
            default:  ordered_sets_d = OS_IDLE;
        endcase
        finished_d = (state_d == S_READY);
    end

    // State, counters, config snapshot and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_RESET;
            cnt_q          <= '0;
            vcnt_q         <= '0;
            cc_cnt_q       <= '0;
            burst_q        <= '0;
            single_lane_q  <= 1'b0;
            lane_select_q  <= '0;
            ordered_sets_q <= OS_IDLE;
            finished_q     <= 1'b0;
            cc_active_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            vcnt_q         <= vcnt_d;
            cc_cnt_q       <= cc_cnt_d;
            burst_q        <= burst_d;
            single_lane_q  <= single_lane;
            lane_select_q  <= lane_select;
            ordered_sets_q <= ordered_sets_d;
            finished_q     <= finished_d;
            cc_active_q    <= cc_active_d;
        end
    end

    assign ordered_sets          = ordered_sets_q;
    assign channel_init_finished = finished_q;
    assign cc_active             = cc_active_q;
    assign init_state            = state_q;

endmodule

// File: tb/tb_channel_init_controller.sv
// Scoreboard bench for channel_init_controller: the stimulus process steps a
// phase/elapsed-time reference model and queues the expected outputs; the
// monitor process pops and compares after every clock edge.

module tb_channel_init_controller;
    import channel_init_pkg::*;

    localparam int ML  = 4;
    localparam int MLS = 3;
    localparam int RC  = 8;
    localparam int LIC = 16;
    localparam int BT  = 32;
    localparam int VC  = 4;
    localparam int VT  = 50;
    localparam int CP  = 20;
    localparam int CL  = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           single_lane = 1'b0;
    logic [MLS-1:0] lane_select = '0;
    logic [ML-1:0]  rx_lane_up = '0;
    logic           rx_bonded = 1'b0;
    logic           rx_verify = 1'b0;
    ordered_sets_e  ordered_sets;
    logic           channel_init_finished;
    logic           cc_active;
    logic [2:0]     init_state;

    channel_init_controller #(
        .MAX_LINKS(ML), .MAX_LINKS_SIZE(MLS), .RESET_CYCLES(RC),
        .LANE_INIT_CYCLES(LIC), .BOND_TIMEOUT(BT), .VERIFY_COUNT(VC),
        .VERIFY_TIMEOUT(VT), .CC_PERIOD(CP), .CC_LEN(CL)
    ) dut (
        .clk(clk), .rst(rst), .single_lane(single_lane), .lane_select(lane_select),
        .rx_lane_up(rx_lane_up), .rx_bonded(rx_bonded), .rx_verify(rx_verify),
        .ordered_sets(ordered_sets), .channel_init_finished(channel_init_finished),
        .cc_active(cc_active), .init_state(init_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        ordered_sets_e os;
        logic          fin;
        logic          cc;
        logic [2:0]    st;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: phase 0..4 and cycles elapsed since entering it.
    int       m_phase, m_t, m_run, m_pulses;
    logic     m_prev_sl;
    logic [MLS-1:0] m_prev_ls;

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_t = 0; m_run = 0; m_pulses = 0;
        m_prev_sl = 1'b0; m_prev_ls = '0;
    endtask

    task automatic model_step();
        bit ok, chg;
        int nxt, p;
        if (single_lane)
            ok = (int'(lane_select) < ML) ? rx_lane_up[lane_select] : 1'b0;
        else
            ok = &rx_lane_up;
        chg = (single_lane != m_prev_sl) || (lane_select != m_prev_ls);
        nxt = m_phase;
        case (m_phase)
            0: if (m_t + 1 == RC) nxt = 1;
            1: if (ok && m_run + 1 == LIC) nxt = single_lane ? 3 : 2;
            2: if (rx_bonded) nxt = 3; else if (m_t + 1 == BT) nxt = 1;
            3: begin
                p = m_pulses + (rx_verify ? 1 : 0);
                if (p >= VC) nxt = 4; else if (m_t + 1 == VT) nxt = 1;
            end
            default: ;
        endcase
        if (m_phase >= 2 && (!ok || chg)) nxt = 1;
        if (nxt != m_phase) begin
            m_phase = nxt; m_t = 0; m_run = 0; m_pulses = 0;
        end else begin
            m_t++;
            if (m_phase == 1) m_run = ok ? m_run + 1 : 0;
            if (m_phase == 3 && rx_verify && m_pulses < VC) m_pulses++;
        end
        m_prev_sl = single_lane;
        m_prev_ls = lane_select;
    endtask

    task automatic push_expected();
        exp_t e;
        e.st  = 3'(m_phase);
        e.fin = (m_phase == 4);
        e.cc  = (m_phase == 4) && (m_t >= CP) && ((m_t % CP) < CL);
        case (m_phase)
            2:       e.os = ((m_t % 4) == 0) ? OS_CHANNEL_BOND : OS_IDLE;
            3:       e.os = OS_VERIFY;
            4:       e.os = e.cc ? OS_CLOCK_COMP : OS_NONE;
            default: e.os = OS_IDLE;
        endcase
        sb_q.push_back(e);
    endtask

    // Inputs are already set (at a negedge); predict the next edge, then wait.
    task automatic step();
        model_step();
        push_expected();
        @(negedge clk);
    endtask

    task automatic pulse_verify();
        rx_verify = 1'b1; step(); rx_verify = 1'b0;
    endtask

    task automatic bond_pulse();
        rx_bonded = 1'b1; step(); rx_bonded = 1'b0;
    endtask

    task automatic run_until(int ph, int tt, int limit, string what);
        int n = 0;
        while (!(m_phase == ph && m_t == tt) && n < limit) begin
            step();
            n++;
        end
        if (!(m_phase == ph && m_t == tt)) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got state %0d cycle %0d, expected state %0d cycle %0d", what, m_phase, m_t, ph, tt);
        end
    endtask

    // Asserted at a negedge; outputs must already be at reset values 1ns later.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_ordered_sets", int'(ordered_sets), int'(OS_IDLE));
        check("rst_finished", int'(channel_init_finished), 0);
        check("rst_cc_active", int'(cc_active), 0);
        check("rst_init_state", int'(init_state), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: compare DUT outputs against the scoreboard after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("init_state", int'(init_state), int'(e.st));
                check("ordered_sets", int'(ordered_sets), int'(e.os));
                check("channel_init_finished", int'(channel_init_finished), int'(e.fin));
                check("cc_active", int'(cc_active), int'(e.cc));
            end
        end
    end

    // Stimulus
    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Multi-lane bring-up, bonding at bond cycle 10, 4 spaced verify pulses.
        single_lane = 1'b0; lane_select = '0; rx_lane_up = 4'hF;
        run_until(2, 10, 100, "reach_bond_cycle10");
        bond_pulse();
        for (int i = 0; i < 4; i++) begin
            pulse_verify();
            if (i < 3) begin step(); step(); end
        end

        // Ready with a CC burst under way, then a lane-0 drop at cycle 22.
        run_until(4, 22, 100, "reach_ready_cycle22");
        rx_lane_up = 4'hE; step(); rx_lane_up = 4'hF;

        // Single lane 2: bonding skipped; long ready dwell covers two bursts.
        single_lane = 1'b1; lane_select = 3'd2; rx_lane_up = 4'b0100;
        run_until(3, 0, 100, "single_lane_to_verify");
        for (int i = 0; i < 4; i++) begin pulse_verify(); step(); end
        run_until(4, 50, 100, "single_lane_ready50");

        // Out-of-range lane select: must stay in lane init.
        lane_select = 3'(ML); rx_lane_up = 4'hF;
        for (int i = 0; i < 100; i++) step();

        // Bond timeout, then verify 4th pulse on the timeout cycle.
        single_lane = 1'b0; lane_select = '0;
        run_until(2, 0, 100, "reach_bond");
        run_until(1, 0, 100, "bond_timeout");
        run_until(2, 3, 100, "reach_bond_cycle3");
        bond_pulse();
        for (int i = 0; i < 3; i++) pulse_verify();
        run_until(3, VT - 1, 100, "verify_last_cycle");
        pulse_verify();
        for (int i = 0; i < 3; i++) step();

        // Plain verify timeout with too few pulses.
        rx_lane_up = 4'h7; step(); rx_lane_up = 4'hF;
        run_until(2, 0, 100, "reach_bond_again");
        bond_pulse();
        pulse_verify(); pulse_verify();
        run_until(1, 0, 100, "verify_timeout");

        // Asynchronous reset mid-verify, then full restart to ready.
        run_until(2, 0, 100, "reach_bond_pre_rst");
        bond_pulse();
        run_until(3, 5, 100, "reach_verify_cycle5");
        do_reset();
        run_until(2, 1, 100, "restart_bond");
        bond_pulse();
        for (int i = 0; i < 4; i++) pulse_verify();
        for (int i = 0; i < 5; i++) step();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) single_lane = ~single_lane;
            if ($urandom_range(0, 299) == 0) lane_select = 3'($urandom_range(0, 7));
            if (single_lane && $urandom_range(0, 1) == 0) lane_select = 3'($urandom_range(0, 3));
            rx_lane_up = ($urandom_range(0, 199) == 0) ? 4'($urandom) : 4'hF;
            rx_bonded  = ($urandom_range(0, 14) == 0);
            rx_verify  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            else step();
        end
        rx_bonded = 1'b0; rx_verify = 1'b0;

        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
